// File: rtl/gray_sobel_edge_pkg.sv
// Shared widths and small arithmetic helpers for the streaming Sobel edge detector.
package gray_sobel_edge_pkg;

  localparam int PIX_W   = 8;
  localparam int COORD_W = 16;
  localparam int SOBEL_W = 11;
  localparam int MAG_MAX = 255;

  function automatic logic signed [SOBEL_W-1:0] pixExt(input logic [PIX_W-1:0] p);
    return signed'({{(SOBEL_W-PIX_W){1'b0}}, p});
  endfunction

  function automatic logic [SOBEL_W-1:0] absVal(input logic signed [SOBEL_W-1:0] v);
    return v[SOBEL_W-1] ? SOBEL_W'(-v) : SOBEL_W'(v);
  endfunction

endpackage

// File: rtl/gray_sobel_edge_line_buffer.sv
// Two chained line memories holding rows y-1 and y-2, single-port read-before-write.
module gray_line_buffer2
  import gray_sobel_edge_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 640
) (
  input  logic              iCLK,
  input  logic              iEn,
  input  logic [ADDR_W-1:0] iAddr,
  input  logic [PIX_W-1:0]  iData,
  output logic [PIX_W-1:0]  oLine1,
  output logic [PIX_W-1:0]  oLine2
);

  logic [PIX_W-1:0] line1Mem [DEPTH];
  logic [PIX_W-1:0] line2Mem [DEPTH];

  // Old line1 contents shift down into line2 on the same access that reads them.
  always_ff @(posedge iCLK) begin
    if (iEn) begin
      oLine1          <= line1Mem[iAddr];
      oLine2          <= line2Mem[iAddr];
      line1Mem[iAddr] <= iData;
      line2Mem[iAddr] <= line1Mem[iAddr];
    end
  end

endmodule

// File: rtl/gray_sobel_edge.sv
// Streaming 3x3 Sobel edge detector: saturated |Gx|+|Gy|, threshold bit, centre coordinates.
module gray_sobel_edge
  import gray_sobel_edge_pkg::*;
#(
  parameter int IMG_WIDTH = 640,
  parameter int ADDR_W    = 10
) (
  input  logic               iCLK,
  input  logic               iReset_n,
  input  logic [PIX_W-1:0]   iGray,
  input  logic               iDval,
  input  logic [COORD_W-1:0] iX_Cont,
  input  logic [COORD_W-1:0] iY_Cont,
  input  logic [PIX_W-1:0]   iThresh,
  output logic [PIX_W-1:0]   oEdge,
  output logic               oEdgeBin,
  output logic [COORD_W-1:0] oX_Cont,
  output logic [COORD_W-1:0] oY_Cont,
  output logic               oDval
);

  logic [PIX_W-1:0]   line1, line2;
  logic               s0Valid_q, s1Valid_q, s2Valid_q;
  logic [PIX_W-1:0]   s0Gray_q;
  logic [COORD_W-1:0] s0X_q, s0Y_q, s1X_q, s1Y_q, s2X_q, s2Y_q;
  logic [2:0][2:0][PIX_W-1:0] win_q;
  logic signed [SOBEL_W-1:0] gx_d, gy_d, gx_q, gy_q;
  logic [SOBEL_W-1:0] mag_d;
  logic [PIX_W-1:0]   sat_d, edge_d;
  logic               border_d, bin_d, dval_d;
  logic [PIX_W-1:0]   oEdge_q;
  logic               oEdgeBin_q, oDval_q;
  logic [COORD_W-1:0] oX_q, oY_q;

  gray_line_buffer2 #(.ADDR_W(ADDR_W), .DEPTH(IMG_WIDTH)) uLineBuf (
    .iCLK   (iCLK),
    .iEn    (iDval),
    .iAddr  (iX_Cont[ADDR_W-1:0]),
    .iData  (iGray),
    .oLine1 (line1),
    .oLine2 (line2)
  );

  always_ff @(posedge iCLK or negedge iReset_n) begin
    if (!iReset_n) begin
      s0Valid_q <= 1'b0;
      s0Gray_q  <= '0;
      s0X_q     <= '0;
      s0Y_q     <= '0;
    end else begin
      s0Valid_q <= iDval;
      s0Gray_q  <= iGray;
      s0X_q     <= iX_Cont;
      s0Y_q     <= iY_Cont;
    end
  end

  // Window only advances on real pixels so bubbles leave it intact; row 0 is the oldest line.
  always_ff @(posedge iCLK or negedge iReset_n) begin
    if (!iReset_n) begin
      win_q     <= '0;
      s1Valid_q <= 1'b0;
      s1X_q     <= '0;
      s1Y_q     <= '0;
    end else begin
      s1Valid_q <= s0Valid_q;
      s1X_q     <= s0X_q;
      s1Y_q     <= s0Y_q;
      if (s0Valid_q) begin
        for (int r = 0; r < 3; r++) begin
          win_q[r][0] <= win_q[r][1];
          win_q[r][1] <= win_q[r][2];
        end
        win_q[0][2] <= line2;
        win_q[1][2] <= line1;
        win_q[2][2] <= s0Gray_q;
      end
    end
  end

  always_comb begin
    gx_d = (pixExt(win_q[0][2]) + (pixExt(win_q[1][2]) <<< 1) + pixExt(win_q[2][2]))
         - (pixExt(win_q[0][0]) + (pixExt(win_q[1][0]) <<< 1) + pixExt(win_q[2][0]));
    gy_d = (pixExt(win_q[2][0]) + (pixExt(win_q[2][1]) <<< 1) + pixExt(win_q[2][2]))
         - (pixExt(win_q[0][0]) + (pixExt(win_q[0][1]) <<< 1) + pixExt(win_q[0][2]));
  end

  always_ff @(posedge iCLK or negedge iReset_n) begin
    if (!iReset_n) begin
      gx_q      <= '0;
      gy_q      <= '0;
      s2Valid_q <= 1'b0;
      s2X_q     <= '0;
      s2Y_q     <= '0;
    end else begin
      gx_q      <= gx_d;
      gy_q      <= gy_d;
      s2Valid_q <= s1Valid_q;
      s2X_q     <= s1X_q;
      s2Y_q     <= s1Y_q;
    end
  end

  // Input column/row 1 maps to centre 0, whose window straddles a line or frame boundary.
  always_comb begin
    mag_d    = absVal(gx_q) + absVal(gy_q);
    sat_d    = (mag_d > SOBEL_W'(MAG_MAX)) ? PIX_W'(MAG_MAX) : mag_d[PIX_W-1:0];
    border_d = (s2X_q == COORD_W'(1)) || (s2Y_q == COORD_W'(1));
    edge_d   = border_d ? '0 : sat_d;
    bin_d    = !border_d && (sat_d >= iThresh);
    dval_d   = s2Valid_q && (s2X_q != '0) && (s2Y_q != '0);
  end

  always_ff @(posedge iCLK or negedge iReset_n) begin
    if (!iReset_n) begin
      oEdge_q    <= '0;
      oEdgeBin_q <= 1'b0;
      oDval_q    <= 1'b0;
      oX_q       <= '0;
      oY_q       <= '0;
    end else begin
      oEdge_q    <= edge_d;
      oEdgeBin_q <= bin_d;
      oDval_q    <= dval_d;
      oX_q       <= s2X_q - COORD_W'(1);
      oY_q       <= s2Y_q - COORD_W'(1);
    end
  end

  assign oEdge    = oEdge_q;
  assign oEdgeBin = oEdgeBin_q;
  assign oDval    = oDval_q;
  assign oX_Cont  = oX_q;
  assign oY_Cont  = oY_q;

endmodule

// File: tb/tb_gray_sobel_edge.sv
// Scoreboard bench for gray_sobel_edge on a 16x8 frame: directed patterns, bubbles, mid-frame reset.
module tb_gray_sobel_edge;

  localparam int W = 16;
  localparam int H = 8;
  localparam int PULSES = (W - 1) * (H - 1);

  typedef struct {
    int x;
    int y;
    int edgeVal;
    int bin;
  } expT;

  logic        iCLK, iReset_n;
  logic [7:0]  iGray, iThresh, oEdge;
  logic        iDval, oEdgeBin, oDval;
  logic [15:0] iX_Cont, iY_Cont, oX_Cont, oY_Cont;

  expT expQ[$];
  int  img [H][W];
  int  checkCount = 0;
  int  passCount  = 0;
  int  pulses     = 0;
  int  cyc        = 0;
  int  firstSampleCyc = -1;
  bit  latencyArmed   = 0;

  gray_sobel_edge #(.IMG_WIDTH(W), .ADDR_W(4)) dut (
    .iCLK     (iCLK),
    .iReset_n (iReset_n),
    .iGray    (iGray),
    .iDval    (iDval),
    .iX_Cont  (iX_Cont),
    .iY_Cont  (iY_Cont),
    .iThresh  (iThresh),
    .oEdge    (oEdge),
    .oEdgeBin (oEdgeBin),
    .oX_Cont  (oX_Cont),
    .oY_Cont  (oY_Cont),
    .oDval    (oDval)
  );

  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;
  always @(posedge iCLK) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input longint act, input longint exp);
    checkCount++;
    if (act == exp) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Mode 0 flat, 1 vertical step at x=4, 2 ramp 10*x, 3 mixed texture, 4 different texture for the aborted frame.
  function automatic int pixVal(input int mode, input int x, input int y);
    case (mode)
      0: return 100;
      1: return (x < 4) ? 0 : 200;
      2: return 10 * x;
      3: return (x * 37 + y * 59 + x * y * 11) & 255;
      default: return ((x * 13 + y * 101) ^ 90) & 255;
    endcase
  endfunction

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic int modelEdge(input int cx, input int cy);
    int gx, gy, m;
    gx = (img[cy-1][cx+1] + 2 * img[cy][cx+1] + img[cy+1][cx+1])
       - (img[cy-1][cx-1] + 2 * img[cy][cx-1] + img[cy+1][cx-1]);
    gy = (img[cy+1][cx-1] + 2 * img[cy+1][cx] + img[cy+1][cx+1])
       - (img[cy-1][cx-1] + 2 * img[cy-1][cx] + img[cy-1][cx+1]);
    m = iabs(gx) + iabs(gy);
    return (m > 255) ? 255 : m;
  endfunction

  function automatic int expEdge(input int mode, input int cx, input int cy);
    if (cx == 0 || cy == 0) return 0;
    case (mode)
      0: return 0;
      1: return (cx == 3 || cx == 4) ? 255 : 0;
      2: return 80;
      default: return modelEdge(cx, cy);
    endcase
  endfunction

  task automatic applyStimulus(input int pix, input int x, input int y);
    iGray   = 8'(pix);
    iDval   = 1'b1;
    iX_Cont = 16'(x);
    iY_Cont = 16'(y);
    if (latencyArmed && firstSampleCyc < 0 && x == 1 && y == 1) firstSampleCyc = cyc + 1;
    @(posedge iCLK); #1;
    iDval = 1'b0;
  endtask

  task automatic runFrame(input int mode, input bit bubbles, input int rows);
    expT e;
    int  n;
    pulses = 0;
    for (int y = 0; y < rows; y++) begin
      for (int x = 0; x < W; x++) begin
        img[y][x] = pixVal(mode, x, y);
        if (x >= 1 && y >= 1) begin
          e.x = x - 1;
          e.y = y - 1;
          e.edgeVal = expEdge(mode, x - 1, y - 1);
          e.bin = (x > 1 && y > 1 && e.edgeVal >= int'(iThresh)) ? 1 : 0;
          expQ.push_back(e);
        end
        applyStimulus(img[y][x], x, y);
        if (bubbles) begin
          n = $urandom_range(0, 3);
          repeat (n) begin @(posedge iCLK); #1; end
        end
      end
    end
  endtask

  task automatic endFrame(input string name);
    repeat (8) @(posedge iCLK);
    @(negedge iCLK);
    checkOutput({name, "_drained"}, expQ.size(), 0);
    checkOutput({name, "_pulses"}, pulses, PULSES);
    @(posedge iCLK); #1;
  endtask

  task automatic checkResetOutputs(input string name);
    @(negedge iCLK);
    checkOutput({name, "_oEdge"}, oEdge, 0);
    checkOutput({name, "_oEdgeBin"}, oEdgeBin, 0);
    checkOutput({name, "_oDval"}, oDval, 0);
    checkOutput({name, "_oX"}, oX_Cont, 0);
    checkOutput({name, "_oY"}, oY_Cont, 0);
  endtask

  // Monitor: every output pulse must match the head of the scoreboard queue.
  always @(negedge iCLK) begin
    expT    e;
    longint act, exp;
    if (oDval) begin
      pulses++;
      if (latencyArmed && firstSampleCyc >= 0) begin
        checkOutput("firstLatency", cyc - firstSampleCyc, 3);
        latencyArmed = 0;
      end
      if (expQ.size() == 0) begin
        checkOutput("unexpectedDval", oDval, 0);
      end else begin
        e   = expQ.pop_front();
        act = (longint'(oX_Cont) << 32) | (longint'(oY_Cont) << 16) | (longint'(oEdge) << 1) | longint'(oEdgeBin);
        exp = (longint'(e.x) << 32) | (longint'(e.y) << 16) | (longint'(e.edgeVal) << 1) | longint'(e.bin);
        checkOutput("pixel{x,y,edge,bin}", act, exp);
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    iReset_n = 1'b0;
    iGray = '0; iDval = 1'b0; iX_Cont = '0; iY_Cont = '0; iThresh = 8'd128;
    for (int i = 0; i < 4; i++) begin
      @(posedge iCLK); #1;
      iGray   = 8'($urandom);
      iDval   = 1'($urandom_range(0, 1));
      iX_Cont = 16'($urandom);
      iY_Cont = 16'($urandom);
      iThresh = 8'($urandom);
      checkResetOutputs("reset");
    end
    @(posedge iCLK); #1;
    iDval = 1'b0; iThresh = 8'd128;
    iReset_n = 1'b1;
    latencyArmed = 1;
    @(posedge iCLK); #1;

    runFrame(0, 0, H);  endFrame("flat");
    runFrame(1, 0, H);  endFrame("step");
    iThresh = 8'd81;
    runFrame(2, 0, H);  endFrame("ramp81");
    iThresh = 8'd80;
    runFrame(2, 0, H);  endFrame("ramp80");
    iThresh = 8'd128;
    runFrame(1, 1, H);  endFrame("stepBubbles");

    iThresh = 8'd60;
    runFrame(4, 0, 4);
    iReset_n = 1'b0;
    expQ.delete();
    checkResetOutputs("midReset");
    checkResetOutputs("midReset2");
    @(posedge iCLK); #1;
    iReset_n = 1'b1;
    @(posedge iCLK); #1;
    runFrame(3, 0, H);  endFrame("afterReset");

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/gray_sobel_edge.md
Name: gray_sobel_edge

Overview:
- Streaming 3x3 Sobel edge detector, downstream of the RGB-to-grayscale stage in the camera-to-LCD path.
- Consumes the 8-bit gray pixel stream with valid flag and X/Y counters.
- Outputs a saturated gradient magnitude, a thresholded edge bit, and counters realigned to the window centre.
- Two internal line buffers hold the previous two rows.

Parameters:
- IMG_WIDTH, 640, active pixels per line; iX_Cont never reaches this value.
- ADDR_W, 10, line-buffer address width; 2^ADDR_W >= IMG_WIDTH.

Ports:
- iCLK  in  1  pixel clock
- iReset_n  in  1  asynchronous, active-low reset
- iGray  in  8  gray pixel
- iDval  in  1  pixel valid
- iX_Cont  in  16  column of iGray
- iY_Cont  in  16  row of iGray
- iThresh  in  8  edge threshold, quasi-static
- oEdge  out  8  min(|Gx|+|Gy|, 255)
- oEdgeBin  out  1  oEdge >= iThresh
- oX_Cont  out  16  window-centre column
- oY_Cont  out  16  window-centre row
- oDval  out  1  output valid

Behaviour:
- Reset values: oEdge=0, oEdgeBin=0, oDval=0, oX_Cont=0, oY_Cont=0. All pipeline registers and window registers clear.
- Line-buffer RAM contents are not reset and are don't-care. Reset asserted mid-frame aborts the frame; the next frame starts cleanly.
- S0, input register: captures iGray, iDval and counters every cycle.
  - When iDval=1, line buffer is addressed by iX_Cont[ADDR_W-1:0].
  - Read returns old contents of line1 (y-1) and line2 (y-2), registered.
  - Same access writes gray into line1 and old line1 into line2 (read-before-write).
- S1, window: when the S0 valid bit=1, the 3x3 window shifts left.
  - New right column = {line2, line1, current}, top to bottom.
  - Window holds while valid=0.
- S2, gradients, with signed 11-bit arithmetic:
  - Gx = (p02+2p12+p22) - (p00+2p10+p20)
  - Gy = (p20+2p21+p22) - (p00+2p01+p02)
  - pRC: row 0 = oldest line, col 2 = newest pixel.
- S3, output: mag = |Gx|+|Gy| (11-bit unsigned, max 2040), saturated to 255 into oEdge. oEdgeBin = (sat mag >= iThresh).
- Latency: iDval sampled high at edge k gives oDval high after edge k+3, for exactly one cycle per input pixel. iDval bubbles propagate as oDval=0 and do not corrupt the window.
- Coordinates: the output for input pixel (x,y) is the centre (x-1, y-1).
  - Outputs with input x==0 or y==0 are emitted with oDval=0 (no valid centre).
  - Emitted frame is (IMG_WIDTH-1) x (H-1) centres, starting at (0,0) of the original image.
  - Border centres (oX_Cont==0 or oY_Cont==0) force oEdge=0 and oEdgeBin=0, because the window spans a row/frame boundary.
- Counters pass through the pipeline unchanged apart from the -1 offset; no wrap handling is needed since x,y >= 1 when valid.
- iThresh is sampled at S3.

Decomposition:
- Shared package constants: PIX_W=8, COORD_W=16, SOBEL_W=11, MAG_MAX=255. No typedefs needed.
- Sub-module gray_line_buffer2: single-port read-before-write RAM pair.
  - Ports: iCLK, iEn, iAddr, iData[7:0], oLine1[7:0], oLine2[7:0].
  - Registered read, infers block RAM.

Test Plan:
- Reset values: hold iReset_n=0 with random inputs -> all outputs 0. Release, then drive a 16x8 frame -> first oDval 3 cycles after the pixel (1,1) is sampled, with oX_Cont=0, oY_Cont=0, oEdge=0.
- Flat frame: all pixels 100, IMG_WIDTH=16 -> every valid output oEdge=0, oEdgeBin=0; count of oDval pulses = 15*7 = 105.
- Vertical step: pixel = 0 for x<4, 200 for x>=4, iThresh=128 -> interior centres x=3 and x=4 give oEdge=255, oEdgeBin=1; x=2 and x>=5 give 0; Gy=0 throughout.
- Small gradient: pixel = 10*x -> interior Gx=80, Gy=0 -> oEdge=80; oEdgeBin=0 at iThresh=81, 1 at iThresh=80.
- Valid bubbles: repeat the step test with iDval low for random 0-3 cycles between pixels -> identical oEdge sequence and coordinates. oDval never asserts without a preceding input pixel.
- Mid-frame reset: pulse iReset_n low at row 4 -> outputs 0 within the reset. A following full frame matches the golden model exactly, with no stale rows leaking into interior centres (rows 0-1 are borders or invalid).
